counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
Run/step/clear controller for the free-running 32-bit LED counter datapath in the FPGA user design. It synchronizes and debounces the board button and switch pins. It classifies button presses as short or long. It sequences the counter through idle, continuous-run, pause and single-step operation by driving the counter's enable and clear strobes.

Parameters:
DB_CYCLES, 50000, consecutive stable cycles required before a debounced input changes (>=2)
LONG_CYCLES, 25000000, debounced-button hold cycles that qualify as a long press (> DB_CYCLES)
RUN_DIV, 1, in RUN, ctr_en pulses once every RUN_DIV cycles (1 = every cycle)
CNT_W, 26, width of debounce/hold/prescale counters; must hold LONG_CYCLES and RUN_DIV

Ports:
clk  input  1  fabric clock
rst_n  input  1  reset; synchronous, active-low
btn_raw  input  1  asynchronous button pin (1 = pressed)
sw_raw  input  1  asynchronous mode switch pin (1 = continuous, 0 = step)
ctr_en  output  1  counter increment strobe
ctr_clr  output  1  counter synchronous clear strobe, one cycle
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 STEP
btn_db  output  1  debounced button level
sw_db  output  1  debounced switch level

Behaviour:
- Reset: rst_n low at a clk edge sets state=IDLE. It clears ctr_en, ctr_clr, btn_db, sw_db, the synchronizer flops and all counters. Reset mid-operation aborts any press, hold or prescale in progress.
- Synchronizer: two flops per raw input; s2 is the raw value delayed by 2 cycles.
- Debounce, per input:
  - If s2 == db, the stability counter is set to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 with s2 != db, db takes s2 and the counter is set to 0.
  - Net latency from a clean raw edge to the db change is 2 + DB_CYCLES cycles.
  - A glitch shorter than DB_CYCLES cycles produces no change.
- Press classifier:
  - The hold counter counts cycles while btn_db=1 and is set to 0 while btn_db=0.
  - When the hold count reaches LONG_CYCLES-1, long_p pulses for 1 cycle and the press is marked consumed.
  - A btn_db falling edge on an unconsumed press produces short_p for 1 cycle. A consumed press produces nothing on release.
  - At most one of short_p and long_p occurs per press.
- FSM, with transitions on the clk edge following the pulse:
  - IDLE: short_p with sw_db=1 goes to RUN; short_p with sw_db=0 goes to STEP.
  - RUN: short_p goes to PAUSE. sw_db=0 also goes to PAUSE. Both events in the same cycle go to PAUSE.
  - PAUSE: short_p with sw_db=1 goes to RUN; short_p with sw_db=0 goes to STEP.
  - STEP: unconditionally goes to PAUSE after 1 cycle.
  - long_p in any state: ctr_clr=1 for exactly 1 cycle and the next state is IDLE. long_p has priority over every other transition.
- Output timing: ctr_en and ctr_clr are registered and decoded from the current state.
  - RUN: the prescaler is set to 0 on entry. ctr_en=1 in the 1st cycle of RUN and then every RUN_DIV cycles. The prescaler wraps from RUN_DIV-1 to 0.
  - STEP: ctr_en=1 for exactly its single cycle.
  - IDLE and PAUSE: ctr_en=0.
  - ctr_en and ctr_clr are never both 1. ctr_en is 0 in the cycle ctr_clr is 1.
- Switch changes while in IDLE, PAUSE or STEP cause no transition; they only select the target of the next short press.

Test Plan:
Use DB_CYCLES=4, LONG_CYCLES=16, RUN_DIV=3 unless noted.
1. Reset held 3 cycles with btn_raw=1 and sw_raw=1 -> state=0, ctr_en=0, ctr_clr=0, btn_db=0, sw_db=0. btn_db=1 appears 6 cycles after rst_n rises.
2. Debounce: btn_raw pulses high for 3 cycles, then high for 10 cycles -> no btn_db change for the 3-cycle glitch. btn_db rises 6 cycles after the second rising edge.
3. sw=1, short press of 8 debounced cycles from IDLE -> RUN 1 cycle after btn_db falls. ctr_en pattern is 1,0,0,1,0,0. A second short press -> PAUSE with ctr_en=0 thereafter.
4. sw=0, two short presses -> state sequence IDLE,STEP,PAUSE,STEP,PAUSE. Exactly 2 ctr_en pulses total, each 1 cycle wide.
5. In RUN, hold button for 30 debounced cycles -> ctr_clr=1 exactly once, 16 cycles after btn_db rises; state=IDLE. No short_p effect on release; state stays IDLE.
6. In RUN, sw_raw falls -> PAUSE 1 cycle after sw_db falls. With RUN_DIV=1, ctr_en is 1 every RUN cycle and 0 from PAUSE onward.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run/step/clear controller for the 32-bit LED counter datapath.
// Ports: clk, rst_n (sync, active-low), btn_raw, sw_raw in;
//        ctr_en, ctr_clr, state[1:0], btn_db, sw_db out.

module counter_run_ctrl_db #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_db
);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_MAX) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;
endmodule

module counter_run_ctrl #(
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 25000000,
    parameter int RUN_DIV     = 1,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       sw_raw,
    output logic       ctr_en,
    output logic       ctr_clr,
    output logic [1:0] state,
    output logic       btn_db,
    output logic       sw_db
);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             w_btn_db;
    logic             w_sw_db;
    logic             r_btn_prev;
    logic             r_cons;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic             r_en;
    logic             r_clr;
    logic             w_long;
    logic             w_short;

    counter_run_ctrl_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (btn_raw),
        .o_db  (w_btn_db)
    );

    counter_run_ctrl_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (sw_raw),
        .o_db  (w_sw_db)
    );

    // A press that already fired long_p is consumed: it neither
    // fires again nor yields a short press on release.
    assign w_long  = w_btn_db && !r_cons && (r_hold == LONG_MAX);
    assign w_short = r_btn_prev && !w_btn_db && !r_cons;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b0;
            r_cons     <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_btn_prev <= w_btn_db;
            if (w_btn_db) begin
                if (!r_cons && !w_long) begin
                    r_hold <= r_hold + 1'b1;
                end
                r_cons <= r_cons | w_long;
            end else begin
                r_hold <= '0;
                r_cons <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        if (w_long) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (w_short) begin
                        w_nxt = w_sw_db ? S_RUN : S_STEP;
                    end
                end
                S_RUN: begin
                    if (w_short || !w_sw_db) begin
                        w_nxt = S_PAUSE;
                    end
                end
                S_STEP: begin
                    w_nxt = S_PAUSE;
                end
                default: begin
                    w_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_presc_nxt = (r_presc == DIV_MAX) ? '0 : r_presc + 1'b1;

    // ctr_en is decoded from the state being entered so the strobe
    // lines up with the first cycle of RUN/STEP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_clr   <= w_long;
            if (w_nxt == S_RUN) begin
                if (r_state != S_RUN) begin
                    r_presc <= '0;
                    r_en    <= 1'b1;
                end else begin
                    r_presc <= w_presc_nxt;
                    r_en    <= (w_presc_nxt == '0);
                end
            end else begin
                r_presc <= '0;
                r_en    <= (w_nxt == S_STEP);
            end
        end
    end

    assign ctr_en  = r_en;
    assign ctr_clr = r_clr;
    assign state   = r_state;
    assign btn_db  = w_btn_db;
    assign sw_db   = w_sw_db;
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl (RUN_DIV=3 and RUN_DIV=1
// instances driven in parallel) against a behavioural model.

module tb_counter_run_ctrl;
    localparam int DB = 4;
    localparam int LG = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b1;
    logic       sw_raw = 1'b1;
    logic       en3, clr3, bdb3, sdb3;
    logic [1:0] st3;
    logic       en1, clr1, bdb1, sdb1;
    logic [1:0] st1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    counter_run_ctrl #(
        .DB_CYCLES(DB), .LONG_CYCLES(LG), .RUN_DIV(3), .CNT_W(26)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .ctr_en(en3), .ctr_clr(clr3), .state(st3),
        .btn_db(bdb3), .sw_db(sdb3)
    );

    counter_run_ctrl #(
        .DB_CYCLES(DB), .LONG_CYCLES(LG), .RUN_DIV(1), .CNT_W(26)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .ctr_en(en1), .ctr_clr(clr1), .state(st1),
        .btn_db(bdb1), .sw_db(sdb1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raw -> 2-cycle delay line -> level adopted after DB consecutive
    // disagreeing cycles; press length measured in debounced cycles;
    // RUN strobes on every cycle whose index since entry is a
    // multiple of the divider.
    bit m_valid = 0;
    int m_s1[2], m_s2[2], m_db[2], m_run[2];
    int m_prev, m_len, m_cons, m_state, m_k;
    int m_en3, m_en1, m_clr;

    initial begin
        int c_rst, c_btn, c_sw;
        int lp, sp, nx, sw;
        forever begin
            @(posedge clk);
            c_rst = rst_n;
            c_btn = btn_raw;
            c_sw  = sw_raw;
            @(negedge clk);
            if (c_rst == 0) begin
                for (int i = 0; i < 2; i++) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
                end
                m_prev = 0; m_len = 0; m_cons = 0; m_state = 0; m_k = 0;
                m_en3 = 0; m_en1 = 0; m_clr = 0;
                m_valid = 1;
            end else if (m_valid) begin
                lp = (m_db[0] == 1 && m_len == LG - 1 && m_cons == 0) ? 1 : 0;
                sp = (m_prev == 1 && m_db[0] == 0 && m_cons == 0) ? 1 : 0;
                sw = m_db[1];
                nx = m_state;
                if (lp == 1) nx = 0;
                else if (m_state == 0 || m_state == 2) begin
                    if (sp == 1) nx = (sw == 1) ? 1 : 3;
                end else if (m_state == 1) begin
                    if (sp == 1 || sw == 0) nx = 2;
                end else nx = 2;
                if (nx == 1) begin
                    m_k = (m_state == 1) ? m_k + 1 : 0;
                    m_en3 = (m_k % 3 == 0) ? 1 : 0;
                    m_en1 = 1;
                end else begin
                    m_en3 = (nx == 3) ? 1 : 0;
                    m_en1 = m_en3;
                end
                m_clr = lp;
                m_state = nx;
                if (m_db[0] == 1) begin
                    m_len++;
                    if (lp == 1) m_cons = 1;
                end else begin
                    m_len = 0;
                    m_cons = 0;
                end
                m_prev = m_db[0];
                for (int i = 0; i < 2; i++) begin
                    m_run[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
                    if (m_run[i] == DB) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                    m_s2[i] = m_s1[i];
                end
                m_s1[0] = c_btn;
                m_s1[1] = c_sw;
            end
            if (m_valid) begin
                chk("state3", st3, m_state);
                chk("en3", en3, m_en3);
                chk("clr3", clr3, m_clr);
                chk("btn_db3", bdb3, m_db[0]);
                chk("sw_db3", sdb3, m_db[1]);
                chk("state1", st1, m_state);
                chk("en1", en1, m_en1);
                chk("clr1", clr1, m_clr);
                chk("btn_db1", bdb1, m_db[0]);
                chk("sw_db1", sdb1, m_db[1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic stepn(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input logic sw);
        rst_n = 1'b0;
        btn_raw = 1'b0;
        sw_raw = sw;
        stepn(3);
        rst_n = 1'b1;
        stepn(10);
    endtask

    task automatic press(input int n);
        btn_raw = 1'b1;
        stepn(n);
        btn_raw = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        for (int i = 0; i < 60 && st3 != s; i++) stepn(1);
        chk(nm, st3, s);
    endtask

    initial begin
        logic [5:0] pat;
        int n;
        int cnt;

        // reset held with both pins high
        stepn(3);
        chk("rst_state", st3, 0);
        chk("rst_en", en3, 0);
        chk("rst_clr", clr3, 0);
        chk("rst_btn_db", bdb3, 0);
        chk("rst_sw_db", sdb3, 0);
        rst_n = 1'b1;
        stepn(5);
        chk("btn_db_5", bdb3, 0);
        stepn(1);
        chk("btn_db_6", bdb3, 1);
        btn_raw = 1'b0;
        stepn(30);

        // glitch then clean edge
        do_reset(1'b1);
        btn_raw = 1'b1;
        stepn(3);
        btn_raw = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            stepn(1);
            cnt += bdb3;
        end
        chk("glitch", cnt, 0);
        btn_raw = 1'b1;
        stepn(5);
        chk("edge_5", bdb3, 0);
        stepn(1);
        chk("edge_6", bdb3, 1);
        stepn(4);
        btn_raw = 1'b0;
        stepn(20);

        // continuous run with divide-by-3
        do_reset(1'b1);
        press(8);
        wait_state(2'd1, "run3");
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            pat = {pat[4:0], en3};
            if (i < 5) stepn(1);
        end
        chk("en_pattern", pat, 6'b100100);
        press(6);
        wait_state(2'd2, "pause3");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            stepn(1);
            cnt += en3;
        end
        chk("pause_en", cnt, 0);

        // step mode
        do_reset(1'b0);
        cnt = 0;
        for (int p = 0; p < 2; p++) begin
            btn_raw = 1'b1;
            for (int i = 0; i < 6; i++) begin
                stepn(1);
                cnt += en3;
            end
            btn_raw = 1'b0;
            for (int i = 0; i < 20; i++) begin
                stepn(1);
                cnt += en3;
            end
        end
        chk("step_pulses", cnt, 2);
        chk("step_end", st3, 2);

        // long press during RUN
        do_reset(1'b1);
        press(6);
        wait_state(2'd1, "run5");
        btn_raw = 1'b1;
        for (int i = 0; i < 40 && bdb3 == 1'b0; i++) stepn(1);
        chk("db_rise5", bdb3, 1);
        n = 0;
        while (clr3 == 1'b0 && n < 40) begin
            stepn(1);
            n++;
        end
        chk("clr_delay", n, 16);
        chk("clr_state", st3, 0);
        chk("clr_no_en", en3, 0);
        stepn(14);
        btn_raw = 1'b0;
        stepn(20);
        chk("long_release", st3, 0);

        // switch drop during RUN, RUN_DIV=1 instance
        do_reset(1'b1);
        press(6);
        wait_state(2'd1, "run6");
        chk("run1_en", en1, 1);
        sw_raw = 1'b0;
        for (int i = 0; i < 40 && sdb1 == 1'b1; i++) stepn(1);
        chk("sw_fall", sdb1, 0);
        stepn(1);
        chk("sw_pause", st1, 2);
        chk("sw_pause_en", en1, 0);

        // randomized presses and switch flips
        repeat (80) begin
            if ($urandom_range(0, 24) == 0) do_reset(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) sw_raw = ~sw_raw;
            press($urandom_range(1, 24));
            stepn($urandom_range(1, 20));
        end

        stepn(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
